// File: rtl/dff_mem_pkg.sv
// Shared types and default sizes for the burst-access flop memory.
package dff_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_LEN_W  = 4;

endpackage

// File: rtl/dff_mem_array.sv
// Flop-based storage: one synchronous write port, one combinational read port.
module dff_mem_array #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Contents are intentionally never reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dff_mem_burst.sv
// Burst read/write controller in front of dff_mem_array.
// Optional per-word even parity is enabled by defining DFF_MEM_PARITY_EN.
module dff_mem_burst
    import dff_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
`ifdef DFF_MEM_PARITY_EN
    input  logic              wr_perr_inj,
    output logic              rd_perr,
`endif
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

`ifdef DFF_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
`ifdef DFF_MEM_PARITY_EN
    logic              rd_perr_q, rd_perr_d;
`endif

    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WORD_W-1:0] mem_wword;
    logic [WORD_W-1:0] mem_rword;

`ifdef DFF_MEM_PARITY_EN
    assign mem_wword = {(^wr_data) ^ wr_perr_inj, wr_data};
`else
    assign mem_wword = wr_data;
`endif

    // Reset blocks the write so an aborted beat never lands in memory.
    dff_mem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we && !rst),
        .waddr_i (ptr_q),
        .wdata_i (mem_wword),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rword)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
`ifdef DFF_MEM_PARITY_EN
        rd_perr_d  = rd_perr_q;
`endif
        mem_we     = 1'b0;
        mem_raddr  = ptr_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_d = cmd_addr;
                    rem_d = cmd_len;
                    if (cmd_we) begin
                        state_d = WRITE;
                    end else begin
                        // First read beat is fetched at accept time.
                        state_d    = READ;
                        mem_raddr  = cmd_addr;
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem_rword[DATA_W-1:0];
`ifdef DFF_MEM_PARITY_EN
                        rd_perr_d  = ^mem_rword;
`endif
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    mem_we = 1'b1;
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_valid_q && rd_ready) begin
                    if (rem_q == '0) begin
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        rd_data_d = mem_rword[DATA_W-1:0];
`ifdef DFF_MEM_PARITY_EN
                        rd_perr_d = ^mem_rword;
`endif
                        ptr_d     = ptr_q + 1'b1;
                        rem_d     = rem_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef DFF_MEM_PARITY_EN
            rd_perr_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef DFF_MEM_PARITY_EN
            rd_perr_q  <= rd_perr_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
`ifdef DFF_MEM_PARITY_EN
    assign rd_perr   = rd_perr_q;
`endif

endmodule

// File: tb/tb_dff_mem_burst.sv
// Directed bench for dff_mem_burst (DATA_W=8, ADDR_W=4, LEN_W=4).
module tb_dff_mem_burst;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       busy;
`ifdef DFF_MEM_PARITY_EN
    logic       wr_perr_inj;
    logic       rd_perr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dff_mem_burst #(
        .DATA_W (8),
        .ADDR_W (4),
        .LEN_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
`ifdef DFF_MEM_PARITY_EN
        .wr_perr_inj (wr_perr_inj),
        .rd_perr     (rd_perr),
`endif
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_cmd(input logic [3:0] a, input logic [3:0] l);
        chk("cmd_ready_before_wr", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
        chk("wr_ready_after_accept", {31'd0, wr_ready}, 32'd1);
    endtask

    task automatic wr_beat(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd_cmd(input logic [3:0] a, input logic [3:0] l);
        chk("cmd_ready_before_rd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rd_beat(input logic [7:0] exp);
        chk("rd_valid_beat", {31'd0, rd_valid}, 32'd1);
        chk("rd_data_beat", {24'd0, rd_data}, {24'd0, exp});
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
`ifdef DFF_MEM_PARITY_EN
        wr_perr_inj = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);

        // Single write then single read
        wr_cmd(4'h1, 4'd0);
        chk("single_wr_busy", {31'd0, busy}, 32'd1);
        wr_beat(8'hAA);
        chk_idle("single_wr_done");
        rd_cmd(4'h1, 4'd0);
        chk("single_rd_busy", {31'd0, busy}, 32'd1);
        rd_beat(8'hAA);
        chk_idle("single_rd_done");

        // Wrapping write burst with a stall, then read back
        wr_cmd(4'hE, 4'd3);
        wr_beat(8'h10);
        tick();
        chk("wr_stall_busy", {31'd0, busy}, 32'd1);
        chk("wr_stall_ready", {31'd0, wr_ready}, 32'd1);
        wr_beat(8'h11);
        wr_beat(8'h12);
        wr_beat(8'h13);
        chk_idle("wrap_wr_done");
        rd_cmd(4'hE, 4'd3);
        rd_beat(8'h10);
        rd_beat(8'h11);
        rd_beat(8'h12);
        rd_beat(8'h13);
        chk_idle("wrap_rd_done");
        rd_cmd(4'h0, 4'd1);
        rd_beat(8'h12);
        rd_beat(8'h13);
        chk_idle("wrap_rd2_done");

        // Read backpressure mid-burst
        wr_cmd(4'h4, 4'd2);
        wr_beat(8'h21);
        wr_beat(8'h22);
        wr_beat(8'h23);
        rd_cmd(4'h4, 4'd2);
        rd_beat(8'h21);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_rd_valid", {31'd0, rd_valid}, 32'd1);
            chk("bp_rd_data", {24'd0, rd_data}, 32'h22);
        end
        rd_beat(8'h22);
        rd_beat(8'h23);
        chk_idle("bp_done");

        // cmd_valid held during a write burst
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h8; cmd_len = 4'd1;
        tick();
        cmd_we = 1'b0;
        chk("hold_cmd_ready_0", {31'd0, cmd_ready}, 32'd0);
        wr_valid = 1'b1; wr_data = 8'h31;
        tick();
        chk("hold_cmd_ready_1", {31'd0, cmd_ready}, 32'd0);
        chk("hold_busy_1", {31'd0, busy}, 32'd1);
        wr_data = 8'h32;
        tick();
        wr_valid = 1'b0;
        chk("hold_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("hold_busy_after", {31'd0, busy}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("hold_rd_busy", {31'd0, busy}, 32'd1);
        rd_beat(8'h31);
        rd_beat(8'h32);
        chk_idle("hold_done");

        // Reset during a write burst after two beats
        wr_cmd(4'hA, 4'd3);
        wr_beat(8'h40);
        wr_beat(8'h41);
        wr_beat(8'h42);
        wr_beat(8'h43);
        wr_cmd(4'hA, 4'd3);
        wr_beat(8'h50);
        wr_beat(8'h51);
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h52;
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        chk_idle("rst_wr");
        chk("rst_wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_wr_wr_ready", {31'd0, wr_ready}, 32'd0);
        rd_cmd(4'hA, 4'd3);
        rd_beat(8'h50);
        rd_beat(8'h51);
        rd_beat(8'h42);
        rd_beat(8'h43);
        chk_idle("rst_wr_rd_done");

        // Reset during a read burst clears read outputs
        rd_cmd(4'hA, 4'd3);
        rst = 1'b1; rd_ready = 1'b1;
        tick();
        rst = 1'b0; rd_ready = 1'b0;
        chk_idle("rst_rd");
        chk("rst_rd_data_clr", {24'd0, rd_data}, 32'd0);

`ifdef DFF_MEM_PARITY_EN
        // Parity injection and clean word
        wr_perr_inj = 1'b1;
        wr_cmd(4'h3, 4'd0);
        wr_beat(8'h5A);
        wr_perr_inj = 1'b0;
        wr_cmd(4'h5, 4'd0);
        wr_beat(8'h5B);
        rd_cmd(4'h3, 4'd0);
        chk("perr_inj", {31'd0, rd_perr}, 32'd1);
        rd_beat(8'h5A);
        rd_cmd(4'h5, 4'd0);
        chk("perr_clean", {31'd0, rd_perr}, 32'd0);
        rd_beat(8'h5B);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
